// File: rtl/inst_aligner.sv
// Halfword realignment queue between fetch and an RV32IC decoder: splits 32-bit fetch words
// into 16/32-bit instructions with PCs. Optional macro: INST_ALIGNER_ZERO_ILLEGAL_EN.
module inst_aligner #(
    parameter int DEPTH_HW = 8,
    parameter int PC_W     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [PC_W-1:0]             flush_pc,
    input  logic                        fetch_valid,
    output logic                        fetch_ready,
    input  logic [31:0]                 fetch_data,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [31:0]                 inst_data,
    output logic [PC_W-1:0]             inst_pc,
    output logic                        inst_is_compressed,
    output logic                        inst_illegal,
    output logic [$clog2(DEPTH_HW):0]   count
);
    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and flush cancels any transfer in its cycle.

    logic [15:0]       buf_q [DEPTH_HW];
    logic [15:0]       buf_d [DEPTH_HW];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              skip_first_q, skip_first_d;

    logic [15:0]       h0, h1;
    logic              head_comp, head_valid, head_illegal, push_block;
    logic              push, pop;
    logic [CNT_W-1:0]  push_n, pop_n;
    logic              unused_pc_bit;

    assign unused_pc_bit = flush_pc[0];

    assign h0         = buf_q[rd_ptr_q];
    assign h1         = buf_q[rd_ptr_q + PTR_W'(1)];
    assign head_comp  = (h0[1:0] != 2'b11);
    assign head_valid = ((count_q >= CNT_W'(1)) && head_comp) || (count_q >= CNT_W'(2));

`ifdef INST_ALIGNER_ZERO_ILLEGAL_EN
    logic lock_q, lock_d;
    assign head_illegal = head_valid && (h0 == 16'h0000);
    assign push_block   = lock_q;
`else
    assign head_illegal = 1'b0;
    assign push_block   = 1'b0;
`endif

    assign fetch_ready = (count_q <= CNT_W'(DEPTH_HW - 2)) && !push_block;
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = head_valid && inst_ready && !flush;
    assign push_n      = !push ? CNT_W'(0) : (skip_first_q ? CNT_W'(1) : CNT_W'(2));
    assign pop_n       = !pop ? CNT_W'(0) : (head_comp ? CNT_W'(1) : CNT_W'(2));

    always_comb begin
        buf_d        = buf_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        pc_d         = pc_q;
        skip_first_d = skip_first_q;
`ifdef INST_ALIGNER_ZERO_ILLEGAL_EN
        lock_d       = lock_q;
`endif
        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            pc_d         = {flush_pc[PC_W-1:1], 1'b0};
            skip_first_d = flush_pc[1];
`ifdef INST_ALIGNER_ZERO_ILLEGAL_EN
            lock_d       = 1'b0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
                pc_d     = pc_q + (head_comp ? PC_W'(2) : PC_W'(4));
`ifdef INST_ALIGNER_ZERO_ILLEGAL_EN
                if (head_illegal) lock_d = 1'b1;
`endif
            end
            // A redirect into the upper half of a word keeps only that upper halfword.
            if (push) begin
                if (skip_first_q) begin
                    buf_d[wr_ptr_q] = fetch_data[31:16];
                    skip_first_d    = 1'b0;
                end else begin
                    buf_d[wr_ptr_q]              = fetch_data[15:0];
                    buf_d[wr_ptr_q + PTR_W'(1)]  = fetch_data[31:16];
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            end
            count_d = count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            pc_q         <= '0;
            skip_first_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pc_q         <= pc_d;
            skip_first_q <= skip_first_d;
        end
    end

`ifdef INST_ALIGNER_ZERO_ILLEGAL_EN
    always_ff @(posedge clk) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`endif

    // Storage is only ever read under count, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign inst_valid         = head_valid;
    assign inst_data          = !head_valid ? 32'h0 : (head_comp ? {16'h0, h0} : {h1, h0});
    assign inst_pc            = pc_q;
    assign inst_is_compressed = (count_q != '0) && head_comp;
    assign inst_illegal       = head_illegal;
    assign count              = count_q;
endmodule

// File: tb/tb_inst_aligner.sv
// Testbench for inst_aligner: directed steps then random traffic, all checked against a
// halfword-queue reference model.
module tb_inst_aligner;
    localparam int DEPTH_HW = 8;
    localparam int PC_W     = 32;
`ifdef INST_ALIGNER_ZERO_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            flush;
    logic [PC_W-1:0] flush_pc;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [PC_W-1:0] inst_pc;
    logic            inst_is_compressed;
    logic            inst_illegal;
    logic [$clog2(DEPTH_HW):0] count;

    inst_aligner #(.DEPTH_HW(DEPTH_HW), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_is_compressed(inst_is_compressed),
        .inst_illegal(inst_illegal), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued halfwords, head PC, pending skip and illegal lock.
    logic [15:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_skip;
    bit          m_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int          sz;
        logic [15:0] h0, h1;
        bit          comp, vld, rdy, ill;
        sz   = exp_q.size();
        h0   = (sz > 0) ? exp_q[0] : 16'h0;
        h1   = (sz > 1) ? exp_q[1] : 16'h0;
        comp = (h0[1:0] != 2'b11);
        vld  = (sz >= 1 && comp) || (sz >= 2);
        rdy  = (sz <= DEPTH_HW - 2) && !m_lock;
        ill  = ILL_EN && vld && (h0 == 16'h0);
        chk("count", 32'(count), 32'(sz));
        chk("fetch_ready", 32'(fetch_ready), 32'(rdy));
        chk("inst_valid", 32'(inst_valid), 32'(vld));
        chk("inst_pc", inst_pc, m_pc);
        chk("inst_illegal", 32'(inst_illegal), 32'(ill));
        if (sz >= 1) chk("inst_is_compressed", 32'(inst_is_compressed), 32'(comp));
        if (vld) chk("inst_data", inst_data, comp ? {16'h0, h0} : {h1, h0});
    endtask

    task automatic update_model();
        int          sz;
        logic [15:0] h0;
        bit          comp, vld, rdy;
        sz   = exp_q.size();
        h0   = (sz > 0) ? exp_q[0] : 16'h0;
        comp = (h0[1:0] != 2'b11);
        vld  = (sz >= 1 && comp) || (sz >= 2);
        rdy  = (sz <= DEPTH_HW - 2) && !m_lock;
        if (reset) begin
            exp_q.delete();
            m_pc = 0; m_skip = 0; m_lock = 0;
        end else if (flush) begin
            exp_q.delete();
            m_pc = {flush_pc[31:1], 1'b0}; m_skip = flush_pc[1]; m_lock = 0;
        end else begin
            if (vld && inst_ready) begin
                if (ILL_EN && h0 == 16'h0) m_lock = 1;
                void'(exp_q.pop_front());
                if (!comp) void'(exp_q.pop_front());
                m_pc = m_pc + (comp ? 32'd2 : 32'd4);
            end
            if (fetch_valid && rdy) begin
                if (m_skip) begin
                    exp_q.push_back(fetch_data[31:16]);
                    m_skip = 0;
                end else begin
                    exp_q.push_back(fetch_data[15:0]);
                    exp_q.push_back(fetch_data[31:16]);
                end
            end
        end
    endtask

    // Outputs depend only on registered state, so checking right after driving is safe.
    task automatic cycle();
        if (!reset) check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drive(input bit fv, input logic [31:0] fd, input bit ir,
                         input bit fl, input logic [31:0] fpc);
        fetch_valid = fv; fetch_data = fd; inst_ready = ir; flush = fl; flush_pc = fpc;
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] hw;
        hw = 16'($urandom);
        if ($urandom_range(0, 1) == 0) hw[1:0] = 2'b11;
        if (ILL_EN && $urandom_range(0, 39) == 0) hw = 16'h0;
        return hw;
    endfunction

    logic [31:0] fill_words [4];

    initial begin
        reset = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0);
        m_pc = 0; m_skip = 0; m_lock = 0;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_comp", 32'(inst_is_compressed), 32'h0);
        chk("rst_illegal", 32'(inst_illegal), 32'h0);
        chk("rst_count", 32'(count), 32'h0);

        // Two full-width instructions, one cycle latency each
        drive(1, 32'h0000_0013, 1, 0, 0); cycle();
        drive(1, 32'h00A0_0093, 1, 0, 0);
        chk("t1_valid0", 32'(inst_valid), 32'h1);
        chk("t1_data0", inst_data, 32'h0000_0013);
        chk("t1_pc0", inst_pc, 32'h0);
        cycle();
        drive(0, 32'h0, 1, 0, 0);
        chk("t1_data1", inst_data, 32'h00A0_0093);
        chk("t1_pc1", inst_pc, 32'h4);
        cycle();

        // Two compressed instructions from one word
        drive(0, 32'h0, 0, 1, 32'h0); cycle();
        drive(1, 32'h4501_4581, 1, 0, 0); cycle();
        drive(0, 32'h0, 1, 0, 0);
        chk("t2_data0", inst_data, 32'h0000_4581);
        chk("t2_comp0", 32'(inst_is_compressed), 32'h1);
        cycle();
        chk("t2_data1", inst_data, 32'h0000_4501);
        chk("t2_pc1", inst_pc, 32'h2);
        chk("t2_comp1", 32'(inst_is_compressed), 32'h1);
        cycle();

        // Straddling 32-bit instruction waits for the next word
        drive(0, 32'h0, 0, 1, 32'h0); cycle();
        drive(1, 32'h0013_4501, 1, 0, 0); cycle();
        drive(0, 32'h0, 1, 0, 0);
        chk("t3_data0", inst_data, 32'h0000_4501);
        cycle();
        chk("t3_straddle_hold", 32'(inst_valid), 32'h0);
        drive(1, 32'h4581_0000, 1, 0, 0); cycle();
        drive(0, 32'h0, 1, 0, 0);
        chk("t3_data1", inst_data, 32'h0000_0013);
        chk("t3_pc1", inst_pc, 32'h2);
        chk("t3_comp1", 32'(inst_is_compressed), 32'h0);
        cycle();
        chk("t3_data2", inst_data, 32'h0000_4581);
        chk("t3_pc2", inst_pc, 32'h6);
        cycle();

        // Fill to capacity, then drain across the wrap point
        drive(0, 32'h0, 0, 1, 32'h0); cycle();
        fill_words[0] = 32'h0000_0013;
        fill_words[1] = 32'h4501_4581;
        fill_words[2] = 32'h00A0_0093;
        fill_words[3] = 32'h4581_4501;
        for (int i = 0; i < 4; i++) begin
            drive(1, fill_words[i], 0, 0, 0);
            cycle();
        end
        drive(0, 32'h0, 1, 0, 0);
        chk("t4_full_count", 32'(count), 32'd8);
        chk("t4_full_ready", 32'(fetch_ready), 32'h0);
        for (int i = 0; i < 16; i++) cycle();

        // Flush into an upper halfword drops the flush-cycle word
        drive(1, 32'h1111_1111, 0, 0, 0); cycle();
        drive(1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0103); cycle();
        drive(1, 32'h0013_4581, 1, 0, 0);
        chk("t5_flush_count", 32'(count), 32'h0);
        chk("t5_flush_pc", inst_pc, 32'h0000_0102);
        cycle();
        drive(1, 32'h1234_5678, 1, 0, 0);
        chk("t5_hold", 32'(inst_valid), 32'h0);
        cycle();
        drive(0, 32'h0, 1, 0, 0);
        chk("t5_data0", inst_data, 32'h5678_0013);
        chk("t5_pc0", inst_pc, 32'h0000_0102);
        cycle();
        chk("t5_data1", inst_data, 32'h0000_1234);
        chk("t5_pc1", inst_pc, 32'h0000_0106);
        cycle();

        // All-zero halfword
        drive(0, 32'h0, 0, 1, 32'h0); cycle();
        drive(1, 32'h0000_0000, 0, 0, 0); cycle();
        drive(0, 32'h0, 1, 0, 0);
        chk("t6_illegal", 32'(inst_illegal), 32'(ILL_EN));
        chk("t6_valid", 32'(inst_valid), 32'h1);
        chk("t6_data", inst_data, 32'h0);
        cycle();
        drive(1, 32'h0000_0013, 0, 0, 0);
        chk("t6_ready_after_pop", 32'(fetch_ready), 32'(!ILL_EN));
        cycle();
        drive(0, 32'h0, 0, 1, 32'h0); cycle();
        drive(0, 32'h0, 0, 0, 0);
        chk("t6_ready_after_flush", 32'(fetch_ready), 32'h1);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, {rand_hw(), rand_hw()},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_aligner.md
Name: inst_aligner

Overview:
- Halfword-granular instruction realignment queue between the fetch stage and the RV32IC decoder.
- Accepts 32-bit sequential fetch words and splits them into 16-bit compressed or 32-bit full instructions, including 32-bit instructions that straddle a word boundary.
- Presents one aligned instruction per cycle with its PC over a valid/ready handshake.
- Supports redirect (flush) to any halfword-aligned PC.

Parameters:
- DEPTH_HW, 8, queue capacity in halfwords; power of 2, minimum 4.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  redirect; discard queue contents and restart at flush_pc.
- flush_pc  in  PC_W  redirect target; bit 0 ignored.
- fetch_valid  in  1  fetch_data holds the next sequential word.
- fetch_ready  out  1  queue can accept a word this cycle.
- fetch_data  in  32  fetched word, little-endian: halfword 0 = [15:0].
- inst_valid  out  1  inst_data/inst_pc hold a complete instruction.
- inst_ready  in  1  decoder consumes the instruction.
- inst_data  out  32  instruction; compressed instructions are zero-extended to [31:16]=0.
- inst_pc  out  PC_W  PC of inst_data.
- inst_is_compressed  out  1  head instruction is 16-bit (head[1:0] != 2'b11).
- inst_illegal  out  1  see Optional Feature; tied 0 when the feature is absent.
- count  out  $clog2(DEPTH_HW)+1  halfwords currently queued.

Behaviour:
- Storage: circular halfword buffer with rd_ptr, wr_ptr and count, plus a registered head PC and a skip_first flag.
- Reset values:
  - count=0, pointers=0, head PC=0, skip_first=0.
  - Outputs: inst_valid=0, fetch_ready=1, inst_data=0, inst_is_compressed=0, inst_illegal=0.
- fetch_ready is combinational: fetch_ready = (count <= DEPTH_HW-2).
- Push (fetch_valid & fetch_ready):
  - Normally writes two halfwords and count increases by 2.
  - If skip_first=1, writes only fetch_data[31:16], count increases by 1, and skip_first clears.
- Head decode is combinational from registered buffer state:
  - Head halfword h0, next halfword h1.
  - compressed = (h0[1:0] != 2'b11).
  - inst_valid = (count>=1 & compressed) | (count>=2).
  - inst_data = compressed ? {16'h0,h0} : {h1,h0}.
- Pop (inst_valid & inst_ready):
  - rd_ptr and count advance by 1 if compressed, else by 2.
  - Head PC advances by 2 or 4 respectively.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. A pop may free space, but fetch_ready must not depend on inst_ready.
- Latency: a word pushed in cycle N is visible at the output in cycle N+1. There is no same-cycle bypass.
- Straddle case: a 32-bit instruction whose low half is the last queued halfword holds inst_valid=0 until the next push.
- Flush has priority over push and pop in the same cycle. It forces:
  - count=0 and rd_ptr=wr_ptr=0;
  - head PC = {flush_pc[PC_W-1:1],1'b0};
  - skip_first = flush_pc[1].
  - fetch_data presented in the flush cycle is dropped; fetch must resupply from the word containing flush_pc.
- Reset takes precedence over flush.
- Wrap-around: pointers wrap modulo DEPTH_HW. A 32-bit instruction may span index DEPTH_HW-1 and index 0.
- The block never overflows because fetch_ready guarantees 2 free halfwords. Underflow is impossible because pop requires inst_valid.
- The block emits no illegal-opcode detection of its own; that remains the decoder's job.

Optional Feature:
- Macro: INST_ALIGNER_ZERO_ILLEGAL_EN.
- When defined:
  - inst_illegal = inst_valid & (h0 == 16'h0000), i.e. the all-zero compressed encoding is architecturally illegal.
  - An illegal head is still popped as a compressed instruction.
  - After the illegal head is popped, the aligner refuses further pushes (fetch_ready=0) until flush or reset.
- When undefined: inst_illegal is constant 0 and 16'h0000 is passed through as an ordinary compressed instruction.

Test Plan:
- Reset, then push 0x00000013 and 0x00A00093 with inst_ready=1. Expect inst_data 0x00000013 @pc 0, then 0x00A00093 @pc 4, with inst_valid asserted 1 cycle after each push.
- Push 0x45014581 → two compressed instructions: 0x00004581 @pc 0 and 0x00004501 @pc 2, both with inst_is_compressed=1.
- Push 0x00134501 then 0x4581_0000:
  - Expect 0x4501 @pc 0.
  - The straddling 32-bit instruction has low half 0x0013 (from the first word) and high half 0x0000 (from the second word); expect it to be held invalid until the second push, then output inst_data 0x00000013 @pc 2.
  - Then expect 0x4581 @pc 6.
- Hold inst_ready=0 and push until fetch_ready=0 with DEPTH_HW=8 → count=8 and fetch_ready low. Then pop with no push over 16 cycles, verifying pointer wrap and correct PC sequence.
- Flush with flush_pc=0x102 in the same cycle as fetch_valid/inst_ready, then push 0x00134581 → flush-cycle data dropped, first output is 0x4581... is skipped: output is the halfword 0x0013 as the low half of a 32-bit instruction @pc 0x102, completed on the next push.
- With INST_ALIGNER_ZERO_ILLEGAL_EN defined, push 0x00000000 → inst_illegal=1 @pc 0 and fetch_ready stays 0 after the pop until flush. With the macro undefined, inst_illegal stays 0.
